// File: rtl/ahbl_uart_pkg.sv
// Shared definitions for the AHB-Lite UART transmitter: register offsets, bit indices, tx states.
package ahbl_uart_pkg;

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_BAUD   = 2'd2;
  localparam logic [1:0] OFF_CTRL   = 2'd3;

  localparam int unsigned STATUS_FULL    = 0;
  localparam int unsigned STATUS_EMPTY   = 1;
  localparam int unsigned STATUS_BUSY    = 2;
  localparam int unsigned STATUS_OVR     = 3;
  localparam int unsigned STATUS_CNT_LSB = 4;
  localparam int unsigned STATUS_CNT_W   = 4;

  localparam int unsigned CTRL_EN = 0;
  localparam int unsigned CTRL_IE = 1;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full is taken only alongside a pop.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8,
  localparam int unsigned AddrW = $clog2(Depth),
  localparam int unsigned CntW  = $clog2(Depth) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout,
  output logic [CntW-1:0]  count,
  output logic             full,
  output logic             empty
);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wptr_q, wptr_d;
  logic [AddrW-1:0] rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CntW'(Depth));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rptr_q];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) begin
      wptr_d = wptr_q + AddrW'(1);
    end
    if (do_pop) begin
      rptr_d = rptr_q + AddrW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CntW'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= din;
    end
  end

endmodule

// File: rtl/ahbl_uart_tx.sv
// AHB-Lite slave UART transmitter: zero-wait-state register file, byte FIFO and 8N1 tx engine.
module ahbl_uart_tx
  import ahbl_uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        UART_TXD,
  output logic        UART_IRQ
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  // Bus pipeline: address phase latched, access performed in the data phase.
  logic       acc_ph;
  logic       dp_valid_q, dp_write_q;
  logic [1:0] dp_addr_q;
  logic       wr_en, rd_en;
  logic       wr_data, wr_status, wr_baud, wr_ctrl;

  logic [15:0] baud_q;
  logic [1:0]  ctrl_q;
  logic        ovr_q;

  logic            fifo_pop;
  logic [7:0]      fifo_dout;
  logic [CntW-1:0] fifo_count;
  logic            fifo_full, fifo_empty;

  tx_state_e   state_q, state_d;
  logic [15:0] bit_cnt_q, bit_cnt_d;
  logic [15:0] div_q, div_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        txd_q, txd_d;
  logic        irq_q, irq_d;

  logic        bit_tick, can_start, start_frame, busy;
  logic [31:0] status;
  logic        unused_bits;

  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HSIZE, HTRANS[0], HWDATA[31:16]};

  assign acc_ph = HSEL & HREADY & HTRANS[1];

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_addr_q  <= OFF_DATA;
    end else begin
      dp_valid_q <= acc_ph;
      dp_write_q <= HWRITE;
      dp_addr_q  <= HADDR[3:2];
    end
  end

  assign wr_en     = dp_valid_q & dp_write_q;
  assign rd_en     = dp_valid_q & ~dp_write_q;
  assign wr_data   = wr_en & (dp_addr_q == OFF_DATA);
  assign wr_status = wr_en & (dp_addr_q == OFF_STATUS);
  assign wr_baud   = wr_en & (dp_addr_q == OFF_BAUD);
  assign wr_ctrl   = wr_en & (dp_addr_q == OFF_CTRL);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      baud_q <= DEFAULT_DIV;
      ctrl_q <= 2'b00;
      ovr_q  <= 1'b0;
    end else begin
      if (wr_baud) begin
        baud_q <= HWDATA[15:0];
      end
      if (wr_ctrl) begin
        ctrl_q <= HWDATA[1:0];
      end
      // A push into a full FIFO is only lost when no pop frees a slot this cycle.
      if (wr_data && fifo_full && !fifo_pop) begin
        ovr_q <= 1'b1;
      end else if (wr_status && HWDATA[STATUS_OVR]) begin
        ovr_q <= 1'b0;
      end
    end
  end

  sync_fifo #(
    .Width(8),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i(HCLK),
    .rst_i(HRESET),
    .push (wr_data),
    .pop  (fifo_pop),
    .din  (HWDATA[7:0]),
    .dout (fifo_dout),
    .count(fifo_count),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign bit_tick    = (bit_cnt_q == 16'd0);
  assign can_start   = ~fifo_empty & ctrl_q[CTRL_EN];
  assign start_frame = can_start & ((state_q == StIdle) | ((state_q == StStop) & bit_tick));
  assign busy        = (state_q != StIdle);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      div_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      txd_q     <= 1'b1;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      div_q     <= div_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      txd_q     <= txd_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (can_start) state_d = StStart;
      StStart: if (bit_tick) state_d = StData;
      StData:  if (bit_tick && (bit_idx_q == 3'd7)) state_d = StStop;
      StStop:  if (bit_tick) state_d = can_start ? StStart : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    fifo_pop  = 1'b0;
    div_d     = div_q;
    bit_cnt_d = bit_cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    if (start_frame) begin
      // Divisor is frozen per frame so BAUD writes only affect later frames.
      fifo_pop  = 1'b1;
      div_d     = baud_q;
      bit_cnt_d = baud_q;
      bit_idx_d = '0;
      shreg_d   = fifo_dout;
    end else if (state_q != StIdle) begin
      if (bit_tick) begin
        bit_cnt_d = div_q;
        if (state_q == StData) begin
          shreg_d   = {1'b0, shreg_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
        end
      end else begin
        bit_cnt_d = bit_cnt_q - 16'd1;
      end
    end
    unique case (state_d)
      StStart: txd_d = 1'b0;
      StData:  txd_d = shreg_d[0];
      default: txd_d = 1'b1;
    endcase
    irq_d = ctrl_q[CTRL_IE] & fifo_empty & ~busy;
  end

  always_comb begin
    status = '0;
    status[STATUS_FULL]  = fifo_full;
    status[STATUS_EMPTY] = fifo_empty;
    status[STATUS_BUSY]  = busy;
    status[STATUS_OVR]   = ovr_q;
    status[STATUS_CNT_LSB +: STATUS_CNT_W] = STATUS_CNT_W'(fifo_count);
  end

  always_comb begin
    HRDATA = '0;
    if (rd_en) begin
      unique case (dp_addr_q)
        OFF_STATUS: HRDATA = status;
        OFF_BAUD:   HRDATA = {16'd0, baud_q};
        OFF_CTRL:   HRDATA = {30'd0, ctrl_q};
        default:    HRDATA = '0;
      endcase
    end
  end

  assign HREADYOUT = 1'b1;
  assign UART_TXD  = txd_q;
  assign UART_IRQ  = irq_q;

endmodule

// File: tb/tb_ahbl_uart_tx.sv
// Directed bench for ahbl_uart_tx; read data and serial line levels are checked from queues.
module tb_ahbl_uart_tx;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic        HWRITE;
  logic        HREADY;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        UART_TXD;
  logic        UART_IRQ;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd_q[$];
  logic        tx_q[$];

  localparam logic [31:0] A_DATA = 32'h8000_0000;
  localparam logic [31:0] A_STAT = 32'h8000_0004;
  localparam logic [31:0] A_BAUD = 32'h8000_0008;
  localparam logic [31:0] A_CTRL = 32'h8000_000C;

  ahbl_uart_tx dut (
    .HCLK     (HCLK),
    .HRESET   (HRESET),
    .HSEL     (HSEL),
    .HADDR    (HADDR),
    .HTRANS   (HTRANS),
    .HSIZE    (HSIZE),
    .HWRITE   (HWRITE),
    .HREADY   (HREADY),
    .HWDATA   (HWDATA),
    .HREADYOUT(HREADYOUT),
    .HRDATA   (HRDATA),
    .UART_TXD (UART_TXD),
    .UART_IRQ (UART_IRQ)
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = w;
    HADDR  = a;
  endtask

  // All bus tasks start and end 1ns after a rising edge unless noted.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr_phase(a, 1'b1);
    @(posedge HCLK); #1;
    bus_idle();
    HWDATA = d;
    @(posedge HCLK); #1;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
    rd_q.push_back(exp);
    addr_phase(a, 1'b0);
    @(posedge HCLK); #1;
    bus_idle();
    @(negedge HCLK);
    chk(tag, HRDATA, rd_q.pop_front());
    @(posedge HCLK); #1;
  endtask

  // Pipelined write then read; returns at the negedge inside the read data phase.
  task automatic write_read_hold(input logic [31:0] wa, input logic [31:0] d,
                                 input logic [31:0] ra, input logic [31:0] exp,
                                 input string tag);
    rd_q.push_back(exp);
    addr_phase(wa, 1'b1);
    @(posedge HCLK); #1;
    HWDATA = d;
    addr_phase(ra, 1'b0);
    @(posedge HCLK); #1;
    bus_idle();
    @(negedge HCLK);
    chk(tag, HRDATA, rd_q.pop_front());
  endtask

  task automatic write_write(input logic [31:0] a1, input logic [31:0] d1,
                             input logic [31:0] a2, input logic [31:0] d2);
    addr_phase(a1, 1'b1);
    @(posedge HCLK); #1;
    HWDATA = d1;
    addr_phase(a2, 1'b1);
    @(posedge HCLK); #1;
    bus_idle();
    HWDATA = d2;
    @(posedge HCLK); #1;
  endtask

  task automatic push_level(input logic lvl, input int n);
    repeat (n) tx_q.push_back(lvl);
  endtask

  task automatic push_frame(input logic [7:0] b, input int div);
    push_level(1'b0, div + 1);
    for (int i = 0; i < 8; i++) push_level(b[i], div + 1);
    push_level(1'b1, div + 1);
  endtask

  // Compares one expected level per cycle; returns at a negedge.
  task automatic check_serial(input string tag);
    while (tx_q.size() > 0) begin
      @(negedge HCLK);
      chk(tag, {31'd0, UART_TXD}, {31'd0, tx_q.pop_front()});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESET = 1'b1;
    HREADY = 1'b1;
    HSIZE  = 3'b010;
    HADDR  = '0;
    HWDATA = '0;
    bus_idle();
    repeat (3) @(posedge HCLK);
    #1;
    HRESET = 1'b0;

    // Reset state
    @(negedge HCLK);
    chk("rst_txd", {31'd0, UART_TXD}, 32'd1);
    chk("rst_irq", {31'd0, UART_IRQ}, 32'd0);
    chk("rst_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    chk("rst_hrdata", HRDATA, 32'd0);
    @(posedge HCLK); #1;
    bus_read(A_STAT, 32'h02, "rst_status");
    bus_read(A_BAUD, 32'd433, "rst_baud");
    bus_read(A_CTRL, 32'd0, "rst_ctrl");

    // Single frame, DIV=3
    bus_write(A_BAUD, 32'd3);
    bus_write(A_CTRL, 32'd1);
    bus_read(A_BAUD, 32'd3, "sf_baud");
    write_read_hold(A_DATA, 32'hA5, A_STAT, 32'h10, "sf_status_after_push");
    chk("sf_txd_before_start", {31'd0, UART_TXD}, 32'd1);
    push_frame(8'hA5, 3);
    check_serial("sf_txd");
    @(posedge HCLK); #1;
    bus_read(A_STAT, 32'h02, "sf_status_idle");

    // Overflow with EN=0
    bus_write(A_CTRL, 32'd0);
    for (int i = 0; i < 9; i++) bus_write(A_DATA, 32'h10 + i);
    bus_read(A_STAT, 32'h89, "ovf_status");
    chk("ovf_txd_idle", {31'd0, UART_TXD}, 32'd1);
    bus_write(A_STAT, 32'h08);
    bus_read(A_STAT, 32'h81, "ovf_cleared");

    // Push on the exact cycle of the first pop while full
    bus_write(A_BAUD, 32'd0);
    write_write(A_CTRL, 32'd1, A_DATA, 32'h5A);
    bus_read(A_STAT, 32'h85, "pp_status");
    repeat (100) @(posedge HCLK);
    #1;
    bus_read(A_STAT, 32'h02, "pp_drained");

    // Back-to-back frames, DIV=0
    bus_write(A_CTRL, 32'd0);
    bus_write(A_DATA, 32'h3C);
    bus_write(A_DATA, 32'hC3);
    bus_write(A_DATA, 32'h81);
    bus_read(A_STAT, 32'h30, "b2b_queued");
    bus_write(A_CTRL, 32'd1);
    push_level(1'b1, 1);
    push_frame(8'h3C, 0);
    push_frame(8'hC3, 0);
    push_frame(8'h81, 0);
    push_level(1'b1, 2);
    check_serial("b2b_txd");
    @(posedge HCLK); #1;
    bus_read(A_STAT, 32'h02, "b2b_status_idle");

    // Reset in the middle of the data bits, then interrupt
    bus_write(A_BAUD, 32'd3);
    bus_write(A_DATA, 32'h00);
    repeat (6) @(posedge HCLK);
    #1;
    chk("mf_txd_data_bit", {31'd0, UART_TXD}, 32'd0);
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    chk("mf_txd_after_reset", {31'd0, UART_TXD}, 32'd1);
    chk("mf_irq_after_reset", {31'd0, UART_IRQ}, 32'd0);
    chk("mf_hreadyout", {31'd0, HREADYOUT}, 32'd1);
    bus_read(A_STAT, 32'h02, "mf_status");
    bus_read(A_BAUD, 32'd433, "mf_baud");
    bus_read(A_CTRL, 32'd0, "mf_ctrl");
    bus_write(A_CTRL, 32'd3);
    chk("irq_at_commit", {31'd0, UART_IRQ}, 32'd0);
    @(posedge HCLK); #1;
    chk("irq_one_later", {31'd0, UART_IRQ}, 32'd1);
    bus_read(A_CTRL, 32'd3, "irq_ctrl");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ahbl_uart_tx.md
# ahbl_uart_tx

AHB-Lite slave UART transmitter with an internal byte FIFO, occupying splitter slot S3 (base 0x8000_0000) in the Hazard2 SoC, next to PMEM, DMEM and GPIO. The CPU writes bytes over the bus with zero wait states. The block serialises them as 8N1 frames on a single TX pin with a programmable baud divisor. A level interrupt signals when the transmitter has drained.

## Interface
- FIFO_DEPTH, 8, FIFO entries; power of two, at least 2.
- DEFAULT_DIV, 16'd433, reset value of BAUD (50 MHz / 115200).
- Clock and reset: one clock, HCLK. Reset is synchronous and active-high, on port HRESET.
- HCLK  in  1  bus and UART clock.
- HRESET  in  1  synchronous active-high reset.
- HSEL  in  1  slave select from splitter.
- HADDR  in  32  address; only [3:2] decoded.
- HTRANS  in  2  transfer type; HTRANS[1] marks an active transfer.
- HSIZE  in  3  ignored; all accesses treated as word accesses.
- HWRITE  in  1  write when 1.
- HREADY  in  1  bus ready.
- HWDATA  in  32  write data, sampled in the data phase.
- HREADYOUT  out  1  always 1.
- HRDATA  out  32  read data, valid in the data phase.
- UART_TXD  out  1  serial output, registered, idle high.
- UART_IRQ  out  1  registered interrupt, level.

## Operation
- Address phase accepted when HSEL & HREADY & HTRANS[1]. HADDR[3:2] and HWRITE are latched, and the write/read takes effect in the following data phase.
- Register map:
  - 0x0 DATA (W): HWDATA[7:0] is pushed to the FIFO. Reads return 0.
  - 0x4 STATUS (R): [0] FULL, [1] EMPTY, [2] BUSY (FSM not IDLE), [3] OVR, [7:4] count (0..FIFO_DEPTH). Writing 1 to bit 3 clears OVR; other bits are read-only.
  - 0x8 BAUD (R/W): [15:0] DIV. One bit period is DIV+1 cycles.
  - 0xC CTRL (R/W): [0] EN, [1] IE.
- Unused bits read 0. A read of DATA returns 0.
- Push rule: a write is accepted if count < FIFO_DEPTH, or if a pop occurs in the same cycle. Otherwise the byte is dropped, OVR is set and count is unchanged.
- Tx FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START when FIFO not empty & EN. The FIFO is popped and DIV is latched on this transition.
  - START holds TXD=0 for DIV+1 cycles.
  - DATA shifts out 8 bits LSB first, DIV+1 cycles each.
  - STOP holds TXD=1 for DIV+1 cycles.
  - STOP end -> START directly (pop again) if FIFO not empty & EN; otherwise -> IDLE.
- Frame length is exactly 10*(DIV+1) cycles, with no idle gap between back-to-back frames.
- Writing BAUD mid-frame affects only subsequent frames.
- Clearing EN mid-frame lets the current frame finish; no new frame starts.
- UART_IRQ = IE & EMPTY & !BUSY, registered, so it follows its inputs one cycle later.
- Reset (any time, including mid-frame) has the following effect at the next edge:
  - FIFO flushed; FSM to IDLE.
  - UART_TXD=1, UART_IRQ=0.
  - OVR=0, CTRL=0, BAUD=DEFAULT_DIV.
  - HRDATA=0, HREADYOUT=1.

## Timing
- Zero wait states: HREADYOUT is constant 1.
- HRDATA is driven combinationally from the latched offset and the current register state during the data phase.
- DATA write: count increments at the edge ending the data phase (edge E). IDLE -> START occurs at E+1, and UART_TXD falls at E+1.
- A STATUS read in the data phase right after a DATA write data phase reflects the new count.
- Bit boundaries fall every DIV+1 edges. The per-bit counter reloads at each boundary and counts down to 0.
- With DIV=0, one bit lasts one cycle.

## Structure
- Shared package ahbl_uart_pkg holds:
  - Register offsets: OFF_DATA=2'd0, OFF_STATUS=2'd1, OFF_BAUD=2'd2, OFF_CTRL=2'd3.
  - STATUS/CTRL bit indices.
  - The tx state enum.
- Sub-module: sync_fifo (parameterised width and depth).
  - Ports: push, pop, din, dout, count, full, empty.
  - Synchronous active-high reset.
  - Simultaneous push and pop is allowed when full.
- The top level holds the bus interface, registers and tx FSM.

## Test plan
- Reset: after HRESET, UART_TXD=1, UART_IRQ=0, HREADYOUT=1; STATUS reads 0x02; BAUD reads 433.
- Single frame: BAUD=3, CTRL=1, write 0xA5.
  - TXD low one edge after the write commits, for 4 cycles.
  - Then 1,0,1,0,0,1,0,1, each 4 cycles, then stop high for 4 cycles; 40 cycles total.
  - BUSY clears afterwards.
- Overflow: with EN=0, write 9 bytes. STATUS reads count=8, FULL=1, OVR=1. Write 0x08 to STATUS clears OVR.
- Back-to-back: BAUD=0, EN=1, write 3 bytes. 30 contiguous bit cycles, with no idle between each stop bit and the next start bit.
- Simultaneous push/pop: FIFO full, EN=1, write on the exact pop cycle. The byte is accepted, OVR stays 0 and count stays 8.
- Reset mid-frame plus IRQ: assert HRESET during DATA. TXD=1 next edge and STATUS=0x02. Then CTRL=3: IRQ rises one cycle after the CTRL write commits.
